// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the hardwired control sequencer.
//   state_t    : sequencer step encoding (IDLE, T0..T6, HALT, FAULT)
//   op_class_t : execute-phase behaviour class of an opcode
//   OP_*       : 5-bit opcodes found in ir[31:27]
//   *_LSB      : IR field offsets (op, Ra, Rb, Rc)
//   ctrl_t     : bundle of single-bit datapath controls plus halted
//   classify() : maps an opcode to its op_class_t
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT,
      ST_FAULT
   } state_t;

   typedef enum logic [2:0] {
      OPC_BIN,
      OPC_UNARY,
      OPC_MULDIV,
      OPC_NOP,
      OPC_HALT,
      OPC_ILLEGAL
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int unsigned OP_LSB = 27;
   localparam int unsigned RA_LSB = 23;
   localparam int unsigned RB_LSB = 19;
   localparam int unsigned RC_LSB = 15;
   localparam int unsigned RIDXW  = 4;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic pc_in;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic zlo_in;
      logic zhi_in;
      logic zlo_out;
      logic zhi_out;
      logic hi_in;
      logic lo_in;
      logic zlow_sel;
      logic zhigh_sel;
      logic halted;
   } ctrl_t;

   function automatic op_class_t classify(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:  classify = OPC_BIN;
         OP_NEG, OP_NOT:                 classify = OPC_UNARY;
         OP_MUL, OP_DIV:                 classify = OPC_MULDIV;
         OP_NOP:                         classify = OPC_NOP;
         OP_HALT:                        classify = OPC_HALT;
         default:                        classify = OPC_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// reg_onehot_dec: register index to one-hot enable decoder.
//   idx    in  IDXW   register number
//   en     in  1      0 forces an all-zero output
//   onehot out NREGS  bit idx set when en=1 (all zero if idx >= NREGS)
module reg_onehot_dec #(
   parameter int unsigned NREGS = 16,
   parameter int unsigned IDXW  = 4
) (
   input  logic [IDXW-1:0]  idx,
   input  logic             en,
   output logic [NREGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         onehot[i] = en && (idx == IDXW'(i));
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for CPU_Datapath.
// Build option: define SEQ_SINGLE_STEP_EN to add the 'step' input; the
// sequencer then waits in T0 for a step rising edge per instruction.
// Ports:
//   clk, clr(async active-low), run(level), mem_rdy, ir[31:0]   inputs
//   step (only with SEQ_SINGLE_STEP_EN)                           input
//   PCout..IRin, Yin..Loin, ZLowSelect, ZHighSelect               1-bit controls
//   reg_in/reg_out  NREGS one-hot register enables
//   ALUSelection    OPW   ALU op code
//   halted          in HALT;  fault  sticky illegal-op / memory timeout
// All outputs are flops loaded with the decode of the next state, so each
// control is clean for the whole step and cleared immediately by clr.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned NREGS   = 16,
   parameter int unsigned OPW     = 5,
   parameter int unsigned MEM_TMO = 15
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic             mem_rdy,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step,
`endif
   input  logic [31:0]      ir,
   output logic             PCout,
   output logic             MARin,
   output logic             IncPC,
   output logic             PCin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             ZLOin,
   output logic             ZHIin,
   output logic             ZLOout,
   output logic             ZHIout,
   output logic             HIin,
   output logic             Loin,
   output logic             ZLowSelect,
   output logic             ZHighSelect,
   output logic [NREGS-1:0] reg_in,
   output logic [NREGS-1:0] reg_out,
   output logic [OPW-1:0]   ALUSelection,
   output logic             halted,
   output logic             fault
);

   localparam int unsigned TMOW = $clog2(MEM_TMO + 1);
   localparam logic [TMOW-1:0] TMO_LAST = TMOW'(MEM_TMO - 1);

   state_t            state, nxt;
   logic [TMOW-1:0]   tmo, tmo_nxt;
   logic              run_q;
   ctrl_t             ctl_q, ctl_nxt;
   logic [OPW-1:0]    alu_q, alu_nxt;
   logic [NREGS-1:0]  ri_q, ro_q, ri_nxt, ro_nxt;
   logic              fault_q;
   logic              ri_en, ro_en;
   logic [RIDXW-1:0]  ri_idx, ro_idx;
   logic              step_go;
   state_t            go_t0;

   logic [OPW-1:0]    op;
   logic [RIDXW-1:0]  ra, rb, rc;
   op_class_t         cls;
   logic              unused_ir_bits;

   assign op  = ir[OP_LSB +: OPW];
   assign ra  = ir[RA_LSB +: RIDXW];
   assign rb  = ir[RB_LSB +: RIDXW];
   assign rc  = ir[RC_LSB +: RIDXW];
   assign cls = classify(op);
   assign unused_ir_bits = ^ir[RC_LSB-1:0];

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q, armed;
   // A step edge arms one pass through T0; the arm is consumed on leaving T0.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         step_q <= 1'b0;
         armed  <= 1'b0;
      end else begin
         step_q <= step;
         armed  <= (armed && !(state == ST_T0 && nxt == ST_T1)) || (step && !step_q);
      end
   end
   assign step_go = armed;
`else
   assign step_go = 1'b1;
`endif

   // run=0 is honoured only at instruction boundaries.
   assign go_t0 = run ? ST_T0 : ST_IDLE;

   always_comb begin
      nxt     = state;
      tmo_nxt = '0;
      case (state)
         ST_IDLE:  if (run) nxt = ST_T0;
         ST_T0:    if (step_go) nxt = ST_T1;
         ST_T1: begin
            if (mem_rdy)             nxt = ST_T2;
            else if (tmo == TMO_LAST) nxt = ST_FAULT;
            else                      tmo_nxt = tmo + 1'b1;
         end
         ST_T2:    nxt = (cls == OPC_UNARY) ? ST_T4 : ST_T3;
         ST_T3: begin
            case (cls)
               OPC_BIN, OPC_MULDIV: nxt = ST_T4;
               OPC_NOP:             nxt = go_t0;
               OPC_HALT:            nxt = ST_HALT;
               default:             nxt = ST_FAULT;
            endcase
         end
         ST_T4:    nxt = ST_T5;
         ST_T5:    nxt = (cls == OPC_MULDIV) ? ST_T6 : go_t0;
         ST_T6:    nxt = go_t0;
         ST_HALT:  if (run && !run_q) nxt = ST_T0;
         ST_FAULT: nxt = ST_FAULT;
         default:  nxt = ST_IDLE;
      endcase
   end

   // Output decode of the next state; the registered copy is what the step sees.
   always_comb begin
      ctl_nxt = '0;
      alu_nxt = '0;
      ri_en   = 1'b0;
      ro_en   = 1'b0;
      ri_idx  = ra;
      ro_idx  = rb;
      case (nxt)
         ST_T0: begin
            ctl_nxt.pc_out   = 1'b1;
            ctl_nxt.mar_in   = 1'b1;
            ctl_nxt.inc_pc   = 1'b1;
            ctl_nxt.z_in     = 1'b1;
            ctl_nxt.zlo_in   = 1'b1;
            ctl_nxt.zlow_sel = 1'b1;
         end
         ST_T1: begin
            ctl_nxt.zlo_out = 1'b1;
            ctl_nxt.pc_in   = 1'b1;
            ctl_nxt.read    = 1'b1;
            ctl_nxt.mdr_in  = 1'b1;
         end
         ST_T2: begin
            ctl_nxt.mdr_out = 1'b1;
            ctl_nxt.ir_in   = 1'b1;
         end
         ST_T3: begin
            if (cls == OPC_BIN || cls == OPC_MULDIV) begin
               ro_en        = 1'b1;
               ctl_nxt.y_in = 1'b1;
            end
         end
         ST_T4: begin
            ro_en            = 1'b1;
            ro_idx           = (cls == OPC_UNARY) ? rb : rc;
            alu_nxt          = op;
            ctl_nxt.z_in     = 1'b1;
            ctl_nxt.zlo_in   = 1'b1;
            ctl_nxt.zlow_sel = 1'b1;
            if (cls == OPC_MULDIV) begin
               ctl_nxt.zhi_in    = 1'b1;
               ctl_nxt.zhigh_sel = 1'b1;
            end
         end
         ST_T5: begin
            ctl_nxt.zlo_out = 1'b1;
            if (cls == OPC_MULDIV) ctl_nxt.lo_in = 1'b1;
            else                   ri_en = 1'b1;
         end
         ST_T6: begin
            ctl_nxt.zhi_out = 1'b1;
            ctl_nxt.hi_in   = 1'b1;
         end
         ST_HALT:  ctl_nxt.halted = 1'b1;
         default:  ;
      endcase
   end

   reg_onehot_dec #(.NREGS(NREGS), .IDXW(RIDXW)) u_dec_in (
      .idx(ri_idx), .en(ri_en), .onehot(ri_nxt)
   );

   reg_onehot_dec #(.NREGS(NREGS), .IDXW(RIDXW)) u_dec_out (
      .idx(ro_idx), .en(ro_en), .onehot(ro_nxt)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= ST_IDLE;
         tmo     <= '0;
         run_q   <= 1'b0;
         ctl_q   <= '0;
         alu_q   <= '0;
         ri_q    <= '0;
         ro_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= nxt;
         tmo     <= tmo_nxt;
         run_q   <= run;
         ctl_q   <= ctl_nxt;
         alu_q   <= alu_nxt;
         ri_q    <= ri_nxt;
         ro_q    <= ro_nxt;
         fault_q <= fault_q || (nxt == ST_FAULT);
      end
   end

   assign PCout        = ctl_q.pc_out;
   assign MARin        = ctl_q.mar_in;
   assign IncPC        = ctl_q.inc_pc;
   assign PCin         = ctl_q.pc_in;
   assign Read         = ctl_q.read;
   assign MDRin        = ctl_q.mdr_in;
   assign MDRout       = ctl_q.mdr_out;
   assign IRin         = ctl_q.ir_in;
   assign Yin          = ctl_q.y_in;
   assign Zin          = ctl_q.z_in;
   assign ZLOin        = ctl_q.zlo_in;
   assign ZHIin        = ctl_q.zhi_in;
   assign ZLOout       = ctl_q.zlo_out;
   assign ZHIout       = ctl_q.zhi_out;
   assign HIin         = ctl_q.hi_in;
   assign Loin         = ctl_q.lo_in;
   assign ZLowSelect   = ctl_q.zlow_sel;
   assign ZHighSelect  = ctl_q.zhigh_sel;
   assign halted       = ctl_q.halted;
   assign reg_in       = ri_q;
   assign reg_out      = ro_q;
   assign ALUSelection = alu_q;
   assign fault        = fault_q;

endmodule
